// File: rtl/decode_wide_pkg.sv
// ============================================================================
// Module      : decode_wide_pkg
// Description : RV32I decode types and per-instruction decode helpers
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_wide_pkg;

  typedef logic [31:0] t_rv_instr;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_UNK = 3'd7
  } t_ifmt;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_REG  = 2'd1,
    OP_IMM  = 2'd2
  } t_optype;

  typedef enum logic [1:0] {
    SZ_1B = 2'd0,
    SZ_2B = 2'd1,
    SZ_4B = 2'd2
  } t_opsize;

  typedef struct packed {
    t_optype    optype;
    t_opsize    opsize;
    logic [4:0] idx;
  } t_opnd;

  typedef struct packed {
    logic        valid;
    logic [6:0]  opcode;
    t_ifmt       ifmt;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    t_opnd       dst;
    t_opnd       src1;
    t_opnd       src2;
    logic [31:0] imm32;
  } t_uinstr;

  function automatic t_ifmt fmt_of(input logic [6:0] op);
    case (op)
      7'b0110011:                                     fmt_of = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111:                         fmt_of = FMT_I;
      7'b0100011:                                     fmt_of = FMT_S;
      7'b1100011:                                     fmt_of = FMT_B;
      7'b0110111, 7'b0010111:                         fmt_of = FMT_U;
      7'b1101111:                                     fmt_of = FMT_J;
      default:                                        fmt_of = FMT_UNK;
    endcase
  endfunction

  function automatic logic [31:0] imm_i(input t_rv_instr i);
    imm_i = {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input t_rv_instr i);
    imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input t_rv_instr i);
    imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input t_rv_instr i);
    imm_u = {i[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input t_rv_instr i);
    imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic t_opnd mk_opnd(input t_optype t, input logic [4:0] r);
    mk_opnd = '{optype: t, opsize: SZ_4B, idx: r};
  endfunction

  // Invalid lanes decode to all-zero so they can never look like real work.
  function automatic t_uinstr decode_one(input t_rv_instr i, input logic valid);
    t_uinstr u;
    t_ifmt   f;
    u = '0;
    f = fmt_of(i[6:0]);
    if (valid) begin
      u.valid  = 1'b1;
      u.opcode = i[6:0];
      u.ifmt   = f;
      if (f != FMT_UNK) begin
        u.dst  = mk_opnd(OP_NONE, 5'd0);
        u.src1 = mk_opnd(OP_NONE, 5'd0);
        u.src2 = mk_opnd(OP_NONE, 5'd0);
      end
      case (f)
        FMT_R: begin
          u.dst    = mk_opnd(OP_REG, i[11:7]);
          u.src1   = mk_opnd(OP_REG, i[19:15]);
          u.src2   = mk_opnd(OP_REG, i[24:20]);
          u.funct7 = i[31:25];
          u.funct3 = i[14:12];
        end
        FMT_I: begin
          u.dst    = mk_opnd(OP_REG, i[11:7]);
          u.src1   = mk_opnd(OP_REG, i[19:15]);
          u.src2   = mk_opnd(OP_IMM, 5'd0);
          u.funct3 = i[14:12];
          u.imm32  = imm_i(i);
        end
        FMT_S, FMT_B: begin
          u.src1   = mk_opnd(OP_REG, i[19:15]);
          u.src2   = mk_opnd(OP_REG, i[24:20]);
          u.funct3 = i[14:12];
          u.imm32  = (f == FMT_S) ? imm_s(i) : imm_b(i);
        end
        FMT_U: begin
          u.dst   = mk_opnd(OP_REG, i[11:7]);
          u.imm32 = imm_u(i);
        end
        FMT_J: begin
          u.dst   = mk_opnd(OP_REG, i[11:7]);
          u.src2  = mk_opnd(OP_IMM, 5'd0);
          u.imm32 = imm_j(i);
        end
        default: ;
      endcase
    end
    decode_one = u;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_lane.sv
// ============================================================================
// Module      : decode_lane
// Description : Combinational single-lane RV32I decoder with illegal flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_lane
  import decode_wide_pkg::*;
(
  input  t_rv_instr instr,
  input  logic      valid,
  output t_uinstr   uinstr,
  output logic      illegal
);

  assign uinstr  = decode_one(instr, valid);
  assign illegal = valid & (uinstr.ifmt == FMT_UNK);

endmodule

`default_nettype wire

// File: rtl/decode_wide.sv
// ============================================================================
// Module      : decode_wide
// Description : WIDTH-lane decode stage feeding a DEPTH-bundle output queue
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_wide
  import decode_wide_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WIDTH-1:0]       valid_de0,
  input  t_rv_instr [WIDTH-1:0]  instr_de0,
  output logic                   ready_de0,
  input  logic                   flush,
  output logic [WIDTH-1:0]       valid_rd0,
  output t_uinstr [WIDTH-1:0]    uinstr_rd0,
  output logic [WIDTH-1:0]       illegal_rd0,
  input  logic                   ready_rd0
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  t_uinstr [WIDTH-1:0] w_dec;
  logic    [WIDTH-1:0] w_ill;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    decode_lane u_lane (
      .instr   (instr_de0[g]),
      .valid   (valid_de0[g]),
      .uinstr  (w_dec[g]),
      .illegal (w_ill[g])
    );
  end

  t_uinstr [WIDTH-1:0] r_q_uinstr  [DEPTH];
  logic    [WIDTH-1:0] r_q_illegal [DEPTH];
  logic    [PTR_W-1:0] r_wr_ptr;
  logic    [PTR_W-1:0] r_rd_ptr;
  logic    [CNT_W-1:0] r_count;
  logic                r_accept_en;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;

  // MSB is a lap bit: equal pointers mean empty, equal index with differing lap means full.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1))
      ptr_inc = {~p[PTR_W-1], {IDX_W{1'b0}}};
    else
      ptr_inc = p + PTR_W'(1);
  endfunction

  assign w_empty   = (r_rd_ptr == r_wr_ptr);
  assign ready_de0 = r_accept_en & (r_count < CNT_W'(DEPTH));
  assign w_push    = (|valid_de0) & ready_de0 & ~flush;
  assign w_pop     = (|valid_rd0) & ready_rd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_accept_en <= 1'b0;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      r_accept_en <= 1'b1;
      if (flush) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Payload needs no reset: it is only observed through the pointer-qualified head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_uinstr[r_wr_ptr[IDX_W-1:0]]  <= w_dec;
      r_q_illegal[r_wr_ptr[IDX_W-1:0]] <= w_ill;
    end
  end

  always_comb begin
    valid_rd0   = '0;
    uinstr_rd0  = '0;
    illegal_rd0 = '0;
    if (!w_empty) begin
      uinstr_rd0  = r_q_uinstr[r_rd_ptr[IDX_W-1:0]];
      illegal_rd0 = r_q_illegal[r_rd_ptr[IDX_W-1:0]];
      for (int l = 0; l < WIDTH; l++) begin
        valid_rd0[l] = uinstr_rd0[l].valid;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_wide.sv
// ============================================================================
// Module      : tb_decode_wide
// Description : Directed self-checking bench for decode_wide (WIDTH=2, DEPTH=2)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_wide;
  import decode_wide_pkg::*;

  localparam int WIDTH = 2;
  localparam int DEPTH = 2;

  logic                  clk;
  logic                  reset_n;
  logic [WIDTH-1:0]      valid_de0;
  t_rv_instr [WIDTH-1:0] instr_de0;
  logic                  ready_de0;
  logic                  flush;
  logic [WIDTH-1:0]      valid_rd0;
  t_uinstr [WIDTH-1:0]   uinstr_rd0;
  logic [WIDTH-1:0]      illegal_rd0;
  logic                  ready_rd0;

  int n_checks;
  int n_fail;

  decode_wide #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .valid_de0   (valid_de0),
    .instr_de0   (instr_de0),
    .ready_de0   (ready_de0),
    .flush       (flush),
    .valid_rd0   (valid_rd0),
    .uinstr_rd0  (uinstr_rd0),
    .illegal_rd0 (illegal_rd0),
    .ready_rd0   (ready_rd0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic t_opnd op(input t_optype t, input logic [4:0] r);
    op = '{optype: t, opsize: SZ_4B, idx: r};
  endfunction

  function automatic t_uinstr mk(input logic [6:0] opc, input t_ifmt f, input logic [6:0] f7,
                                 input logic [2:0] f3, input t_opnd d, input t_opnd s1,
                                 input t_opnd s2, input logic [31:0] imm);
    mk = '{valid: 1'b1, opcode: opc, ifmt: f, funct7: f7, funct3: f3,
           dst: d, src1: s1, src2: s2, imm32: imm};
  endfunction

  function automatic t_uinstr addi_x1_x0(input logic [31:0] imm);
    addi_x1_x0 = mk(7'h13, FMT_I, 7'h0, 3'h0, op(OP_REG, 5'd1), op(OP_REG, 5'd0),
                    op(OP_IMM, 5'd0), imm);
  endfunction

  t_uinstr exp_u;
  t_uinstr zero_u;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    zero_u    = '0;
    reset_n   = 1'b0;
    valid_de0 = '0;
    instr_de0 = '0;
    flush     = 1'b0;
    ready_rd0 = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_ready", 128'(ready_de0), 128'(1'b0));
    check("rst_valid", 128'(valid_rd0), 128'(2'b00));
    check("rst_uinstr", 128'(uinstr_rd0), 128'(0));
    check("rst_illegal", 128'(illegal_rd0), 128'(2'b00));
    reset_n = 1'b1;
    check("rel_ready_pre", 128'(ready_de0), 128'(1'b0));
    tick();
    check("rel_ready_post", 128'(ready_de0), 128'(1'b1));

    // 1: ADDI x1,x2,-1 on lane0, lane1 invalid
    ready_rd0    = 1'b1;
    valid_de0    = 2'b01;
    instr_de0[0] = 32'hFFF10093;
    instr_de0[1] = 32'h0;
    tick();
    valid_de0 = '0;
    exp_u = mk(7'h13, FMT_I, 7'h0, 3'h0, op(OP_REG, 5'd1), op(OP_REG, 5'd2),
               op(OP_IMM, 5'd0), 32'hFFFFFFFF);
    check("t1_valid", 128'(valid_rd0), 128'(2'b01));
    check("t1_lane0", 128'(uinstr_rd0[0]), 128'(exp_u));
    check("t1_lane1", 128'(uinstr_rd0[1]), 128'(zero_u));
    check("t1_illegal", 128'(illegal_rd0), 128'(2'b00));
    tick();
    check("t1_drained", 128'(valid_rd0), 128'(2'b00));

    // 2: LUI x5 + BEQ x1,x2,-4
    valid_de0    = 2'b11;
    instr_de0[0] = 32'h123452B7;
    instr_de0[1] = 32'hFE208EE3;
    tick();
    valid_de0 = '0;
    check("t2_valid", 128'(valid_rd0), 128'(2'b11));
    exp_u = mk(7'h37, FMT_U, 7'h0, 3'h0, op(OP_REG, 5'd5), op(OP_NONE, 5'd0),
               op(OP_NONE, 5'd0), 32'h12345000);
    check("t2_lui", 128'(uinstr_rd0[0]), 128'(exp_u));
    exp_u = mk(7'h63, FMT_B, 7'h0, 3'h0, op(OP_NONE, 5'd0), op(OP_REG, 5'd1),
               op(OP_REG, 5'd2), 32'hFFFFFFFC);
    check("t2_beq", 128'(uinstr_rd0[1]), 128'(exp_u));
    tick();

    // 3: backpressure, A/B fill the queue, C is held then drained in order
    ready_rd0    = 1'b0;
    valid_de0    = 2'b01;
    instr_de0[0] = 32'h00100093;
    instr_de0[1] = 32'h0;
    tick();
    check("t3_ready_a", 128'(ready_de0), 128'(1'b1));
    check("t3_head_a", 128'(uinstr_rd0[0]), 128'(addi_x1_x0(32'd1)));
    instr_de0[0] = 32'h00200093;
    tick();
    check("t3_ready_b", 128'(ready_de0), 128'(1'b0));
    instr_de0[0] = 32'h00300093;
    tick();
    check("t3_full_hold", 128'(ready_de0), 128'(1'b0));
    check("t3_head_still_a", 128'(uinstr_rd0[0]), 128'(addi_x1_x0(32'd1)));
    ready_rd0 = 1'b1;
    tick();
    check("t3_head_b", 128'(uinstr_rd0[0]), 128'(addi_x1_x0(32'd2)));
    check("t3_ready_after_pop", 128'(ready_de0), 128'(1'b1));
    tick();
    valid_de0 = '0;
    check("t3_head_c", 128'(uinstr_rd0[0]), 128'(addi_x1_x0(32'd3)));
    check("t3_valid_c", 128'(valid_rd0), 128'(2'b01));
    tick();
    check("t3_empty", 128'(valid_rd0), 128'(2'b00));

    // 4: flush with a full queue, then flush racing an accepted push
    ready_rd0    = 1'b0;
    valid_de0    = 2'b01;
    instr_de0[0] = 32'h00100093;
    tick();
    instr_de0[0] = 32'h00200093;
    tick();
    check("t4_full", 128'(ready_de0), 128'(1'b0));
    flush        = 1'b1;
    instr_de0[0] = 32'h00400093;
    tick();
    flush     = 1'b0;
    valid_de0 = '0;
    check("t4_flush_valid", 128'(valid_rd0), 128'(2'b00));
    check("t4_flush_ready", 128'(ready_de0), 128'(1'b1));
    tick();
    check("t4_no_ghost", 128'(valid_rd0), 128'(2'b00));
    valid_de0    = 2'b01;
    instr_de0[0] = 32'h00100093;
    tick();
    flush        = 1'b1;
    instr_de0[0] = 32'h00500093;
    tick();
    flush     = 1'b0;
    valid_de0 = '0;
    check("t4_flush_push_drop", 128'(valid_rd0), 128'(2'b00));
    tick();
    check("t4_flush_push_gone", 128'(valid_rd0), 128'(2'b00));

    // 5: unknown opcode on lane0, SW x2,8(x1) on lane1
    valid_de0    = 2'b11;
    instr_de0[0] = 32'hABCDE07F;
    instr_de0[1] = 32'h0020A423;
    tick();
    valid_de0 = '0;
    check("t5_illegal", 128'(illegal_rd0), 128'(2'b01));
    exp_u = '0;
    exp_u.valid  = 1'b1;
    exp_u.opcode = 7'h7F;
    exp_u.ifmt   = FMT_UNK;
    check("t5_unk_fields", 128'(uinstr_rd0[0]), 128'(exp_u));
    exp_u = mk(7'h23, FMT_S, 7'h0, 3'h2, op(OP_NONE, 5'd0), op(OP_REG, 5'd1),
               op(OP_REG, 5'd2), 32'h00000008);
    check("t5_store", 128'(uinstr_rd0[1]), 128'(exp_u));

    // 6: async reset with one bundle queued
    check("t6_pre_valid", 128'(valid_rd0), 128'(2'b11));
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 128'(valid_rd0), 128'(2'b00));
    check("t6_rst_ready", 128'(ready_de0), 128'(1'b0));
    tick();
    reset_n = 1'b1;
    tick();
    check("t6_rel_ready", 128'(ready_de0), 128'(1'b1));
    check("t6_rel_empty", 128'(valid_rd0), 128'(2'b00));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
